alu_regfile: RTL and testbench

ALU_REGFILE -- requirements
Module: alu_regfile

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_mul_iter.sv | 57 +++++
 rtl/alu_regfile.sv | 166 ++++++++++++++++
 tb/tb_alu_regfile.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/register-file block: op encodings and FSM states.
package alu_pkg;

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpShl = 3'd5;
    localparam logic [2:0] OpShr = 3'd6;
    localparam logic [2:0] OpMul = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMul,
        StDone
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles total.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic               busy_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // done_o marks the final step; prod_o is the product that step completes.
    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CntW'(WIDTH - 1));
    assign prod_o = acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i && !busy_q) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_regfile.sv
// Register file plus multi-cycle ALU sharing one bus; operands are latched at start so
// register writes never disturb an operation in flight.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 4,
    localparam int unsigned SELW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    input  logic             wr_en,
    input  logic [SELW-1:0]  wr_sel,
    input  logic             reg_enable,
    input  logic [SELW-1:0]  rd_sel,
    input  logic             alu_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [SELW-1:0]  sel_a,
    input  logic [SELW-1:0]  sel_b,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    state_e             state_q;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   op_a_q, op_b_q, result_q;
    logic [2:0]         op_q;
    logic               busy_q, done_q;
    logic               c_q, z_q, n_q, v_q;

    logic [WIDTH-1:0]   res_d;
    logic               c_d, v_d;
    logic [WIDTH:0]     ext_sum;
    logic               launch, mul_start, mul_busy, mul_done, complete;
    logic [2*WIDTH-1:0] mul_prod;

    assign launch    = (state_q == StIdle) && start;
    assign mul_start = launch && (op == OpMul);
    assign complete  = (state_q == StExec) || ((state_q == StMul) && mul_busy && mul_done);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (mul_start),
        .a_i     (regs_q[sel_a]),
        .b_i     (regs_q[sel_b]),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    always_comb begin
        ext_sum = '0;
        res_d   = '0;
        c_d     = 1'b0;
        v_d     = 1'b0;
        unique case (op_q)
            OpAdd: begin
                ext_sum = {1'b0, op_a_q} + {1'b0, op_b_q};
                res_d   = ext_sum[WIDTH-1:0];
                c_d     = ext_sum[WIDTH];
                v_d     = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                          (res_d[WIDTH-1] != op_a_q[WIDTH-1]);
            end
            OpSub: begin
                // carry-out of A + ~B + 1 is the inverted borrow
                ext_sum = {1'b0, op_a_q} + {1'b0, ~op_b_q} + (WIDTH+1)'(1);
                res_d   = ext_sum[WIDTH-1:0];
                c_d     = ext_sum[WIDTH];
                v_d     = (op_a_q[WIDTH-1] != op_b_q[WIDTH-1]) &&
                          (res_d[WIDTH-1] != op_a_q[WIDTH-1]);
            end
            OpAnd: res_d = op_a_q & op_b_q;
            OpOr:  res_d = op_a_q | op_b_q;
            OpXor: res_d = op_a_q ^ op_b_q;
            OpShl: begin
                res_d = {op_a_q[WIDTH-2:0], 1'b0};
                c_d   = op_a_q[WIDTH-1];
            end
            OpShr: begin
                res_d = {1'b0, op_a_q[WIDTH-1:1]};
                c_d   = op_a_q[0];
            end
            OpMul: begin
                res_d = mul_prod[WIDTH-1:0];
                c_d   = |mul_prod[2*WIDTH-1:WIDTH];
                v_d   = c_d;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_q     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            if (wr_en) begin
                regs_q[wr_sel] <= bus_in;
            end
            done_q <= 1'b0;
            if (complete) begin
                result_q <= res_d;
                c_q      <= c_d;
                z_q      <= (res_d == '0);
                n_q      <= res_d[WIDTH-1];
                v_q      <= v_d;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= StDone;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (launch) begin
                            op_a_q  <= regs_q[sel_a];
                            op_b_q  <= regs_q[sel_b];
                            op_q    <= op;
                            busy_q  <= 1'b1;
                            state_q <= (op == OpMul) ? StMul : StExec;
                        end
                    end
                    StDone:  state_q <= StIdle;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        if (alu_enable) begin
            bus_out = result_q;
        end else if (reg_enable) begin
            bus_out = regs_q[rd_sel];
        end else begin
            bus_out = '0;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign carry    = c_q;
    assign zero     = z_q;
    assign negative = n_q;
    assign overflow = v_q;

endmodule

// File: tb/tb_alu_regfile.sv
// Scoreboard bench for alu_regfile: stimulus queues expected results, a negedge monitor checks them.
module tb_alu_regfile;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

    typedef struct packed {
        logic [7:0] r;
        logic       c, z, n, v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_in, bus_out;
    logic       wr_en, reg_enable, alu_enable, start;
    logic [1:0] wr_sel, rd_sel, sel_a, sel_b;
    logic [2:0] op;
    logic       busy, done, carry, zero, negative, overflow;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc, busy_cnt, dcount;

    alu_regfile #(
        .WIDTH (8),
        .NREGS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .reg_enable (reg_enable),
        .rd_sel     (rd_sel),
        .alu_enable (alu_enable),
        .start      (start),
        .op         (op),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .busy       (busy),
        .done       (done),
        .carry      (carry),
        .zero       (zero),
        .negative   (negative),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_result", {24'd0, bus_out}, {24'd0, mon_e.r});
                chk("mon_carry", {31'd0, carry}, {31'd0, mon_e.c});
                chk("mon_zero", {31'd0, zero}, {31'd0, mon_e.z});
                chk("mon_negative", {31'd0, negative}, {31'd0, mon_e.n});
                chk("mon_overflow", {31'd0, overflow}, {31'd0, mon_e.v});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] s, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = s; bus_in = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [1:0] s, input logic [7:0] d);
        alu_enable = 1'b0; reg_enable = 1'b1; rd_sel = s;
        #1;
        chk(name, {24'd0, bus_out}, {24'd0, d});
        reg_enable = 1'b0; alu_enable = 1'b1;
    endtask

    task automatic wait_done();
        while (!done && cyc < 50) begin
            if (busy) busy_cnt++;
            tick();
            cyc++;
        end
    endtask

    // Issues one op, checks completion latency and busy length, and leaves the bench in the
    // cycle after done so the next call exercises back-to-back issue.
    task automatic run_op(input logic [2:0] o, input logic [1:0] sa, input logic [1:0] sb,
                          input exp_t e, input int done_cyc);
        exp_q.push_back(e);
        start = 1'b1; op = o; sel_a = sa; sel_b = sb;
        tick();
        start = 1'b0;
        cyc = 1; busy_cnt = 0;
        wait_done();
        chk("done_cycle", cyc, done_cyc);
        chk("busy_cycles", busy_cnt, done_cyc - 1);
        tick();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bus_in = '0; wr_en = 0; wr_sel = '0; reg_enable = 0; rd_sel = '0;
        alu_enable = 1'b1; start = 0; op = '0; sel_a = '0; sel_b = '0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_flags", {28'd0, carry, zero, negative, overflow}, 32'd0);
        chk("rst_result", {24'd0, bus_out}, 32'd0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) read_chk("rst_reg", 2'(i), 8'h00);

        write_reg(2'd0, 8'h7F);
        write_reg(2'd1, 8'h01);
        write_reg(2'd2, 8'h05);
        write_reg(2'd3, 8'h05);
        read_chk("wr_r0", 2'd0, 8'h7F);
        read_chk("wr_r1", 2'd1, 8'h01);

        //                 r      c     z     n     v
        run_op(ADD,  2'd0, 2'd1, '{8'h80, 1'b0, 1'b0, 1'b1, 1'b1}, 2);
        run_op(SUB,  2'd2, 2'd3, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}, 2);
        run_op(SHR,  2'd1, 2'd1, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}, 2);
        run_op(AND_, 2'd0, 2'd2, '{8'h05, 1'b0, 1'b0, 1'b0, 1'b0}, 2);
        run_op(OR_,  2'd1, 2'd0, '{8'h7F, 1'b0, 1'b0, 1'b0, 1'b0}, 2);
        run_op(XOR_, 2'd2, 2'd3, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0}, 2);
        run_op(SHL,  2'd0, 2'd0, '{8'hFE, 1'b0, 1'b0, 1'b1, 1'b0}, 2);
        run_op(SUB,  2'd1, 2'd0, '{8'h82, 1'b0, 1'b0, 1'b1, 1'b0}, 2);
        run_op(ADD,  2'd0, 2'd0, '{8'hFE, 1'b0, 1'b0, 1'b1, 1'b1}, 2);

        // MUL 0x10 * 0x11 with an ignored start and an operand-register write mid-flight
        write_reg(2'd0, 8'h10);
        write_reg(2'd1, 8'h11);
        exp_q.push_back('{8'h10, 1'b1, 1'b0, 1'b0, 1'b1});
        start = 1'b1; op = MUL; sel_a = 2'd0; sel_b = 2'd1;
        tick();
        start = 1'b0;
        cyc = 1; busy_cnt = 0;
        while (!done && cyc < 50) begin
            if (busy) busy_cnt++;
            if (cyc == 2) begin start = 1'b1; op = ADD; end
            else start = 1'b0;
            if (cyc == 3) begin wr_en = 1'b1; wr_sel = 2'd0; bus_in = 8'hFF; end
            else wr_en = 1'b0;
            if (cyc == 5) begin
                chk("hold_result", {24'd0, bus_out}, 32'h0000_00FE);
                chk("hold_flags", {28'd0, carry, zero, negative, overflow}, 32'h3);
            end
            tick();
            cyc++;
        end
        start = 1'b0; wr_en = 1'b0;
        chk("mul_done_cycle", cyc, 9);
        chk("mul_busy_cycles", busy_cnt, 8);
        tick();
        read_chk("mid_write_r0", 2'd0, 8'hFF);
        // back-to-back: FF + 11 = 0x110
        run_op(ADD, 2'd0, 2'd1, '{8'h10, 1'b1, 1'b0, 1'b0, 1'b0}, 2);

        // bus priority
        reg_enable = 1'b1; rd_sel = 2'd3; alu_enable = 1'b1;
        #1 chk("bus_both", {24'd0, bus_out}, 32'h10);
        alu_enable = 1'b0;
        #1 chk("bus_reg", {24'd0, bus_out}, 32'h05);
        reg_enable = 1'b0;
        #1 chk("bus_none", {24'd0, bus_out}, 32'h00);
        alu_enable = 1'b1;

        // reset at MUL cycle 4 aborts without a done pulse
        start = 1'b1; op = MUL; sel_a = 2'd0; sel_b = 2'd1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_flags", {28'd0, carry, zero, negative, overflow}, 32'd0);
        chk("abort_result", {24'd0, bus_out}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) read_chk("abort_reg", 2'(i), 8'h00);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) dcount++;
            tick();
        end
        chk("abort_no_activity", dcount, 0);
        run_op(ADD, 2'd0, 2'd0, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0}, 2);

        tick();
        tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
